rf_write_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the 32-entry register file write port of the factorial datapath.
- Up to four requesters compete for the port; the block grants one write per cycle.
- It drives the registered write address, data and enable, plus the one-hot 32-bit register-select vector the register bank consumes.
- A write counter gives the controller simple progress observability.

---
 rtl/rf_write_arbiter.sv | 134 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Round-robin arbiter and sequencer for the 32-entry register file write
//   port. It grants one write per cycle. Grant, write strobe, address, data
//   and one-hot select are all registered, and they are valid together for
//   one cycle after the request is sampled.
//
// Ports
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   req       per-requester write request, held until its gnt bit is seen
//   req_addr  flattened 5-bit register index per requester (slice i)
//   req_data  flattened write data per requester (slice i)
//   gnt       one-hot grant pulse
//   wr_en     register-file write strobe
//   wr_addr   register index being written
//   wr_data   data being written
//   wr_sel    one-hot register select, zero when wr_en=0
//   wr_count  completed-write counter, wraps
//
// Optional feature macro: RF_WR_ZERO_PROTECT_EN
//   When defined, register 0 is read-only. A winning request that targets
//   address 0 still receives its gnt pulse and advances the pointer, but
//   wr_en and wr_sel stay low and wr_count does not increment.
//
// State | meaning
// IDLE  | no write being issued this cycle
// ISSUE | registered grant/write outputs are active this cycle
module rf_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [5*NUM_REQ-1:0]          req_addr,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr_en,
  output logic [4:0]                    wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [31:0]                   wr_sel,
  output logic [CNT_WIDTH-1:0]          wr_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                  state;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        win;
  logic [PTR_W-1:0]        next_ptr;
  logic                    found;
  logic                    win_wr;
  logic [NUM_REQ-1:0]      elig;
  logic [NUM_REQ-1:0]      win_onehot;
  logic [4:0]              win_addr;
  logic [DATA_WIDTH-1:0]   win_data;

  always_comb begin
    // The requester holding this cycle's grant is excluded so a held req
    // is not re-granted until its requester has had a chance to drop it.
    elig       = req & ~gnt;
    found      = 1'b0;
    win        = '0;
    win_onehot = '0;
    win_addr   = '0;
    win_data   = '0;

    // Two passes give the wrap-around search: indices at or above the
    // pointer first, then everything from 0 if nothing was found.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && elig[i] && (PTR_W'(i) >= rr_ptr)) begin
        found = 1'b1;
        win   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && elig[i]) begin
        found = 1'b1;
        win   = PTR_W'(i);
      end
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && (win == PTR_W'(i))) begin
        win_onehot[i] = 1'b1;
        win_addr      = req_addr[5*i +: 5];
        win_data      = req_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end

    next_ptr = (win == PTR_W'(NUM_REQ-1)) ? '0 : win + 1'b1;

`ifdef RF_WR_ZERO_PROTECT_EN
    win_wr = found && (win_addr != 5'd0);
`else
    win_wr = found;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_sel   <= '0;
      wr_count <= '0;
    end else begin
      gnt    <= win_onehot;
      wr_en  <= win_wr;
      wr_sel <= win_wr ? (32'd1 << win_addr) : 32'd0;
      if (found) begin
        rr_ptr  <= next_ptr;
        wr_addr <= win_addr;
        wr_data <= win_data;
      end
      // Counts the write being issued, so it already reflects it while wr_en is high.
      if (win_wr) begin
        wr_count <= wr_count + 1'b1;
      end
      case (state)
        IDLE:    if (found)  state <= ISSUE;
        ISSUE:   if (!found) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req;
  logic [5*N-1:0]    req_addr;
  logic [DW*N-1:0]   req_data;
  logic [N-1:0]      gnt;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DW-1:0]     wr_data;
  logic [31:0]       wr_sel;
  logic [CW-1:0]     wr_count;

  logic [N-1:0]      rq;
  logic [4:0]        ra [N];
  logic [DW-1:0]     rd [N];

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_ptr;
  int          m_gidx;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [CW-1:0] m_cnt;

`ifdef RF_WR_ZERO_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  always #5 clk = ~clk;

  always_comb begin
    req      = '0;
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req[i]              = rq[i];
      req_addr[5*i +: 5]  = ra[i];
      req_data[DW*i +: DW] = rd[i];
    end
  end

  rf_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_sel   (wr_sel),
    .wr_count (wr_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_gidx = -1;
    m_en   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_cnt  = '0;
  endtask

  // Next-cycle expectation from the current inputs: first requesting index
  // at or after the pointer (mod N), skipping whoever is granted right now.
  task automatic model_step();
    int w;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (w < 0 && rq[i] && i != m_gidx) w = i;
    end
    m_gidx = w;
    if (w >= 0) begin
      m_ptr  = (w + 1) % N;
      m_addr = ra[w];
      m_data = rd[w];
      m_en   = !(PROT && ra[w] == 5'd0);
      if (m_en) m_cnt = m_cnt + 1'b1;
    end else begin
      m_en = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    eg = '0;
    if (m_gidx >= 0) eg[m_gidx] = 1'b1;
    check("gnt", gnt, eg);
    check("wr_en", wr_en, m_en);
    check("wr_sel", wr_sel, m_en ? (32'd1 << m_addr) : 32'd0);
    check("wr_count", wr_count, m_cnt);
    if (m_en) begin
      check("wr_addr", wr_addr, m_addr);
      check("wr_data", wr_data, m_data);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic update_random();
    for (int i = 0; i < N; i++) begin
      if (m_gidx == i) begin
        if ($urandom_range(0, 1) == 0) rq[i] = 1'b0;
        else begin
          ra[i] = 5'($urandom_range(0, 31));
          rd[i] = $urandom;
        end
      end else if (!rq[i]) begin
        if ($urandom_range(0, 2) == 0) begin
          rq[i] = 1'b1;
          ra[i] = 5'($urandom_range(0, 31));
          rd[i] = $urandom;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        rq[i] = 1'b0;
      end
    end
  endtask

  initial begin
    logic [N-1:0] seq [4];
    seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;

    reset_n = 1'b0;
    rq = '1;
    for (int i = 0; i < N; i++) begin
      ra[i] = 5'(i + 3);
      rd[i] = 32'h1000_0000 + i;
    end
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_sel", wr_sel, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);

    reset_n = 1'b1;
    step();
    check("first_gnt", gnt, 4'b0001);

    for (int k = 0; k < 4; k++) begin
      step();
      check("contention_gnt", gnt, seq[k]);
      check("contention_wr_en", wr_en, 1);
    end

    // async reset in the middle of an ISSUE cycle
    #3;
    reset_n = 1'b0;
    #1;
    check("async_gnt", gnt, 0);
    check("async_wr_en", wr_en, 0);
    check("async_wr_sel", wr_sel, 0);
    check("async_wr_count", wr_count, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("restart_gnt", gnt, 4'b0001);

    rq = '0;
    step();
    step();

    rq[2] = 1'b1; ra[2] = 5'd17; rd[2] = 32'hDEADBEEF;
    step();
    check("single_gnt", gnt, 4'b0100);
    check("single_wr_en", wr_en, 1);
    check("single_wr_addr", wr_addr, 17);
    check("single_wr_sel", wr_sel, 32'h0002_0000);
    check("single_wr_data", wr_data, 32'hDEADBEEF);
    rq[2] = 1'b0;
    step();

    rq = 4'b1001;
    step();
    check("wrap_gnt_a", gnt, 4'b1000);
    step();
    check("wrap_gnt_b", gnt, 4'b0001);
    rq = '0;
    step();
    step();

    rq[1] = 1'b1; ra[1] = 5'd0; rd[1] = 32'hCAFE_0001;
    step();
    check("zero_gnt", gnt, 4'b0010);
`ifdef RF_WR_ZERO_PROTECT_EN
    check("zero_wr_en", wr_en, 0);
    check("zero_wr_sel", wr_sel, 0);
`else
    check("zero_wr_en", wr_en, 1);
    check("zero_wr_sel", wr_sel, 32'h1);
`endif
    rq[1] = 1'b0;
    step();

    for (int c = 0; c < 600; c++) begin
      update_random();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
